bola: RTL



---
 rtl/bola.sv | 99 +++++++++
 1 files changed

// File: rtl/bola.sv
// bola: breakout ball motion -- rides the paddle until launch, then steps on a fixed tick
// with wall/paddle reflection, paddle-hit and ball-loss pulses.
module bola #(
  parameter int TICK_DIV     = 250000,
  parameter int PASSO        = 2,
  parameter int BOLA_TAM     = 8,
  parameter int NAVE_LARGURA = 45,
  parameter int TELA_L       = 640,
  parameter int TELA_A       = 480
) (
  input  logic       CLOCK_50,
  input  logic       resetNave,
  input  logic       pausa,
  input  logic       lancar,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  output logic [9:0] x_bola,
  output logic [9:0] y_bola,
  output logic       bateu,
  output logic       perdeu,
  output logic [1:0] estado
);
  typedef enum logic [1:0] {ESPERA = 2'd0, MOVENDO = 2'd1, PERDIDA = 2'd2} st_t;
  localparam int CW = TICK_DIV > 2 ? $clog2(TICK_DIV) : 1;
  localparam logic [9:0] OFF = 10'((NAVE_LARGURA - BOLA_TAM) / 2);
  localparam logic [9:0] T10 = 10'(BOLA_TAM);
  localparam logic [9:0] X0 = 10'(320 + (NAVE_LARGURA - BOLA_TAM) / 2);
  localparam logic [9:0] Y0 = 10'(410 - BOLA_TAM);
  localparam logic [10:0] P = 11'(PASSO);
  localparam logic [10:0] T = 11'(BOLA_TAM);
  localparam logic [10:0] W = 11'(NAVE_LARGURA);
  localparam logic [10:0] L = 11'(TELA_L);
  localparam logic [10:0] A = 11'(TELA_A);
  localparam logic [10:0] TERCO = 11'(NAVE_LARGURA / 3);
  st_t st;
  logic [CW-1:0] cnt;
  logic dx, du;
  logic tick, wl, wr, wt, hit, lost, lado_e, lado_d, ndx, ndu;
  logic [10:0] xb, yb, xn, yn, c, nx, ny;
  assign estado = st;
  assign tick = cnt == CW'(TICK_DIV - 1);
  // 11-bit zero-extended arithmetic keeps every comparison free of 10-bit wraparound
  assign xb = {1'b0, x_bola};
  assign yb = {1'b0, y_bola};
  assign xn = {1'b0, x_nave};
  assign yn = {1'b0, y_nave};
  assign c = xb + (T >> 1);
  assign wl = !dx && xb < P;
  assign wr = dx && xb + T + P > L;
  assign wt = du && yb < P;
  assign hit = !du && yb + T <= yn && yb + T + P >= yn && xb + T > xn && xb < xn + W;
  assign lost = !wt && !hit && yb + T + P > A;
  assign lado_e = c < xn + TERCO;
  assign lado_d = c >= xn + W - TERCO;
  always_comb begin
    nx = wl ? 11'd0 : wr ? L - T : dx ? xb + P : xb - P;
    ny = wt ? 11'd0 : hit ? yn - T : du ? yb - P : yb + P;
    ndx = hit && lado_e ? 1'b0 : hit && lado_d ? 1'b1 : wl ? 1'b1 : wr ? 1'b0 : dx;
    ndu = wt ? 1'b0 : hit ? 1'b1 : du;
  end
  always_ff @(posedge CLOCK_50 or posedge resetNave) begin
    if (resetNave) begin
      st <= ESPERA;
      cnt <= '0;
      x_bola <= X0;
      y_bola <= Y0;
      dx <= 1'b1;
      du <= 1'b1;
      bateu <= 1'b0;
      perdeu <= 1'b0;
    end else if (!pausa) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      bateu <= 1'b0;
      perdeu <= 1'b0;
      if (st == ESPERA) begin
        x_bola <= x_nave + OFF;
        y_bola <= y_nave - T10;
        dx <= 1'b1;
        du <= 1'b1;
        if (lancar) st <= MOVENDO;
      end else if (tick && st == MOVENDO) begin
        if (lost) begin
          st <= PERDIDA;
          perdeu <= 1'b1;
        end else begin
          x_bola <= nx[9:0];
          y_bola <= ny[9:0];
          dx <= ndx;
          du <= ndu;
          bateu <= hit;
        end
      end else if (tick && st == PERDIDA) begin
        st <= ESPERA;
        x_bola <= x_nave + OFF;
        y_bola <= y_nave - T10;
      end
    end
  end
endmodule
